shared_reg_rr_arbiter: RTL and testbench
========================================

// Module: shared_reg_rr_arbiter
// PURPOSE
//   Round-robin arbiter and write sequencer for one shared WIDTH-bit holding register.
//   The register is a bank of D flip-flops with synchronous reset.
//   NREQ requesters compete to load it. The block grants one requester at a time,
//   captures that requester's data and records who wrote last.
//   It also counts completed writes and supports a synchronous clear.
// PARAMETERS
//   NREQ     4   number of requesters, 2..16; IDX_W = $clog2(NREQ) (localparam)
//   WIDTH    8   data width of the shared register
//   COUNT_W  8   width of the write counter, which wraps
// PORTS
//   clk       in   1           clock; all state changes on posedge clk
//   reset     in   1           synchronous, active-low reset
//   req       in   NREQ        per-requester write request; bit i = requester i
//   wdata     in   NREQ*WIDTH  packed write data; requester i uses wdata[i*WIDTH +: WIDTH]
//   clr       in   1           synchronous clear of the shared register, active-high
//   gnt       out  NREQ        registered one-hot grant
//   q         out  WIDTH       shared register contents
//   q_valid   out  1           q holds written data since the last reset or clear
//   owner     out  IDX_W       index of the requester that last wrote q
//   wr_count  out  COUNT_W     number of completed writes, modulo 2^COUNT_W
// BEHAVIOUR
//   Reset (reset==0 at posedge):
//     - Forced values: state=IDLE, gnt=0, q=0, q_valid=0, owner=0, ptr=0, wr_count=0.
//     - Reset overrides everything, including clr.
//     - Reset during GRANT drops the pending write; nothing is written.
//   FSM has two states:
//     - IDLE: if req!=0, pick the winner. Search starts at ptr and goes upward
//       with wrap-around; the first set bit wins. Register gnt = one-hot(winner)
//       and go to GRANT. If req==0, stay in IDLE with gnt=0.
//     - GRANT: gnt is held for exactly one cycle. At the closing edge:
//       q <= wdata[winner], q_valid <= 1, owner <= winner, wr_count <= wr_count+1,
//       ptr <= (winner+1) mod NREQ, gnt <= 0, state <= IDLE.
//   Timing:
//     - Latency from req seen in IDLE to gnt high: 1 cycle.
//     - q updates at the edge ending GRANT. Each write takes 2 cycles.
//     - Peak throughput is 1 write per 2 cycles.
//   Handshake:
//     - A requester holds req and its wdata stable until it samples its gnt bit high.
//     - It may drop req at that same edge.
//     - req still high in the following IDLE cycle counts as a new request.
//     - In GRANT, req and wdata of non-winners are ignored.
//     - If the winner drops req during GRANT, the write still happens with the
//       wdata present in GRANT.
//   Fairness: the winner goes to lowest priority. Under continuous requests every
//     active requester is granted within NREQ grants.
//   clr:
//     - In any state: q <= 0, q_valid <= 0. owner, ptr and wr_count are unchanged.
//     - clr together with the closing edge of GRANT: clr wins and the write is discarded.
//       ptr still advances, gnt still drops, wr_count does NOT increment.
//   Wrap-around:
//     - ptr wraps from NREQ-1 to 0.
//     - wr_count wraps from all-ones to 0 with no flag.
//   Invariants:
//     - gnt is always zero or one-hot, and never high two cycles in a row.
//     - gnt is never high in IDLE.
// TESTING
//   1. Hold reset low 3 cycles with req=4'hF -> gnt=0, q=0, q_valid=0, wr_count=0;
//      first gnt appears 1 cycle after reset is released.
//   2. From reset, req=4'b1010, wdata1=8'h5A -> gnt=4'b0010 for 1 cycle; then q=8'h5A,
//      owner=1, q_valid=1, wr_count=1.
//   3. Hold req=4'b1010 continuously -> grants alternate 1,3,1,3 (ptr wraps 3->0);
//      gnt is never high in back-to-back cycles.
//   4. req=4'hF held -> grant order 0,1,2,3,0; wr_count reaches 5 after 10 cycles.
//   5. clr=1 coincident with the GRANT cycle of requester 2 (wdata2=8'hC3) -> q=0,
//      q_valid=0, wr_count unchanged; next IDLE search starts at 3.
//   6. Reset low during GRANT -> no write; q=0, gnt=0 next cycle.
//      Separately, with COUNT_W=2, do 4 writes -> wr_count wraps to 0.

Source files
------------

// File: rtl/shared_reg_rr_arbiter_if.sv
// Bundle of request/data/clear inputs and grant/register outputs for the
// shared-register round-robin arbiter. The requester side drives the master
// modport; the arbiter uses the slave modport.
interface shared_reg_rr_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [IDX_W-1:0]      owner;
  logic [COUNT_W-1:0]    wr_count;

  modport master (
    output req, wdata, clr,
    input  gnt, q, q_valid, owner, wr_count
  );

  modport slave (
    input  req, wdata, clr,
    output gnt, q, q_valid, owner, wr_count
  );
endinterface

// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared holding register.
// One requester is granted for a single cycle; its data is captured at the
// edge that closes the grant, and it then drops to lowest priority.
//
// state | meaning
// IDLE  | searching req from ptr upward (wrapping); registers one-hot gnt on a hit
// GRANT | gnt high for this one cycle; closing edge writes q (unless clr) and advances ptr
module shared_reg_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  shared_reg_rr_arbiter_if.slave  bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_valid_q, q_valid_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [COUNT_W-1:0] wr_count_q, wr_count_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   win_data;

  // Requester index at offset off above base, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return IDX_W'(sum % NREQ);
  endfunction

  // Round-robin search: first set request at or above ptr, with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_found && bus.req[rr_idx(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_idx(ptr_q, k);
      end
    end
  end

  // Select the latched winner's data slice.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == winner_q) begin
        win_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register and all datapath flops; reset has priority over clr.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      owner_q    <= '0;
      ptr_q      <= '0;
      winner_q   <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next-state logic: a grant always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: grant in IDLE, commit the write when GRANT closes.
  always_comb begin
    gnt_d      = '0;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d    = NREQ'(1) << pick_idx;
          winner_d = pick_idx;
        end
      end
      GRANT: begin
        // ptr advances even when clr discards the write, so fairness is preserved.
        ptr_d = (winner_q == IDX_W'(NREQ - 1)) ? '0 : winner_q + IDX_W'(1);
        if (!bus.clr) begin
          q_d        = win_data;
          q_valid_d  = 1'b1;
          owner_d    = winner_q;
          wr_count_d = wr_count_q + COUNT_W'(1);
        end
      end
      default: ;
    endcase
    if (bus.clr) begin
      q_d       = '0;
      q_valid_d = 1'b0;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.q        = q_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.owner    = owner_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// Bench for shared_reg_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue/integer model.
module tb_shared_reg_rr_arbiter;
  logic clk = 1'b0;
  logic reset;

  shared_reg_rr_arbiter_if #(.NREQ(4), .WIDTH(8), .COUNT_W(8)) bus ();
  shared_reg_rr_arbiter_if #(.NREQ(4), .WIDTH(8), .COUNT_W(2)) bus2 ();

  shared_reg_rr_arbiter #(.NREQ(4), .WIDTH(8), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  shared_reg_rr_arbiter #(.NREQ(4), .WIDTH(8), .COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who is holding the grant (-1 = nobody), rotating pointer, register, count.
  int         m_win   = -1;
  int         m_ptr   = 0;
  logic [7:0] m_q     = 8'h00;
  logic       m_qv    = 1'b0;
  int         m_owner = 0;
  int         m_cnt   = 0;
  logic [3:0] m_gnt   = 4'h0;

  always @(posedge clk) begin
    if (!reset) begin
      m_win = -1; m_ptr = 0; m_q = 8'h00; m_qv = 1'b0; m_owner = 0; m_cnt = 0;
    end else if (m_win >= 0) begin
      m_ptr = (m_win + 1) % 4;
      if (bus.clr) begin
        m_q = 8'h00; m_qv = 1'b0;
      end else begin
        m_q = bus.wdata[m_win*8 +: 8]; m_qv = 1'b1; m_owner = m_win; m_cnt = (m_cnt + 1) % 256;
      end
      m_win = -1;
    end else begin
      if (bus.clr) begin
        m_q = 8'h00; m_qv = 1'b0;
      end
      for (int k = 0; k < 4; k++)
        if (m_win < 0 && bus.req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
    end
    m_gnt = (m_win >= 0) ? 4'(1 << m_win) : 4'h0;
  end

  // Per-cycle comparison of every output against the model, plus grant invariants.
  logic [3:0] prev_gnt = 4'h0;
  always @(negedge clk) begin
    chk("gnt", 32'(bus.gnt), 32'(m_gnt));
    chk("q", 32'(bus.q), 32'(m_q));
    chk("q_valid", 32'(bus.q_valid), 32'(m_qv));
    chk("owner", 32'(bus.owner), 32'(m_owner));
    chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    chk("gnt_back_to_back", 32'(prev_gnt != 4'h0 && bus.gnt != 4'h0), 32'd0);
    prev_gnt = bus.gnt;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin : stim
    logic [3:0] exp_t3 [5];
    exp_t3 = '{4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000};

    reset = 1'b0; bus.req = 4'hF; bus.wdata = '0; bus.clr = 1'b0;
    bus2.req = 4'h0; bus2.wdata = 32'hA5A5A5A5; bus2.clr = 1'b0;

    // Reset held with all requests pending.
    repeat (3) cyc();
    chk("t1_gnt_in_reset", 32'(bus.gnt), 32'h0);
    chk("t1_q_in_reset", 32'(bus.q), 32'h0);
    chk("t1_qv_in_reset", 32'(bus.q_valid), 32'h0);
    chk("t1_cnt_in_reset", 32'(bus.wr_count), 32'h0);
    reset = 1'b1;
    cyc();
    chk("t1_first_gnt", 32'(bus.gnt), 32'h1);

    // Single write from requester 1, then alternating 1/3 under held requests.
    reset = 1'b0; bus.req = 4'h0; cyc();
    reset = 1'b1; bus.req = 4'b1010; bus.wdata[15:8] = 8'h5A;
    cyc(); chk("t2_gnt", 32'(bus.gnt), 32'h2);
    cyc();
    chk("t2_gnt_drop", 32'(bus.gnt), 32'h0);
    chk("t2_q", 32'(bus.q), 32'h5A);
    chk("t2_owner", 32'(bus.owner), 32'h1);
    chk("t2_qv", 32'(bus.q_valid), 32'h1);
    chk("t2_cnt", 32'(bus.wr_count), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("t3_alt_gnt", 32'(bus.gnt), 32'(exp_t3[i]));
    end

    // All four requesting: order 0,1,2,3,0 and five writes in ten cycles.
    reset = 1'b0; bus.req = 4'h0; cyc();
    reset = 1'b1; bus.req = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      chk("t4_gnt", 32'(bus.gnt), (c % 2 == 1) ? 32'(1 << (((c - 1) / 2) % 4)) : 32'h0);
    end
    chk("t4_cnt", 32'(bus.wr_count), 32'd5);

    // clr coinciding with requester 2's grant discards the write; ptr still moves to 3.
    reset = 1'b0; bus.req = 4'h0; cyc();
    reset = 1'b1; bus.req = 4'b0001; bus.wdata[7:0] = 8'h11;
    cyc(); bus.req = 4'h0;
    cyc(); chk("t5_pre_q", 32'(bus.q), 32'h11);
    bus.req = 4'b0100; bus.wdata[23:16] = 8'hC3;
    cyc(); chk("t5_gnt2", 32'(bus.gnt), 32'h4);
    bus.clr = 1'b1; bus.req = 4'h0;
    cyc();
    chk("t5_q_cleared", 32'(bus.q), 32'h0);
    chk("t5_qv_cleared", 32'(bus.q_valid), 32'h0);
    chk("t5_cnt_held", 32'(bus.wr_count), 32'h1);
    chk("t5_owner_held", 32'(bus.owner), 32'h0);
    bus.clr = 1'b0; bus.req = 4'hF;
    cyc(); chk("t5_next_search_from_3", 32'(bus.gnt), 32'h8);

    // Reset during GRANT drops the write; narrow counter wraps after four writes.
    reset = 1'b0; bus.req = 4'h0; cyc();
    reset = 1'b1; bus.req = 4'b0001; bus.wdata[7:0] = 8'h77;
    cyc(); chk("t6_gnt", 32'(bus.gnt), 32'h1);
    reset = 1'b0; bus.req = 4'h0;
    cyc();
    chk("t6_gnt_after_rst", 32'(bus.gnt), 32'h0);
    chk("t6_q_after_rst", 32'(bus.q), 32'h0);
    chk("t6_qv_after_rst", 32'(bus.q_valid), 32'h0);
    chk("t6_cnt_after_rst", 32'(bus.wr_count), 32'h0);
    reset = 1'b1; bus2.req = 4'b0001;
    repeat (6) cyc();
    chk("t6_cnt2_three", 32'(bus2.wr_count), 32'd3);
    repeat (2) cyc();
    chk("t6_cnt2_wrapped", 32'(bus2.wr_count), 32'd0);
    chk("t6_q2_valid", 32'(bus2.q_valid), 32'h1);
    bus2.req = 4'h0;

    // Randomized traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(99) != 0);
      bus.req   = 4'($urandom_range(15));
      bus.wdata = $urandom;
      bus.clr   = ($urandom_range(15) == 0);
      cyc();
    end
    reset = 1'b1; bus.req = 4'h0; bus.clr = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
